// File: rtl/dp_sram_bytemask.sv
// Dual-port, byte-masked SRAM built from one 8-bit storage lane per mask bit; read-first across ports,
// port 0 wins same-lane write conflicts. Define DPRAM_CLEAR_ON_RESET_EN to zero-fill the array after reset.

module dp_sram_bytemask_lane #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  re0,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [7:0]            din0,
    input  logic [7:0]            din1,
    output logic [7:0]            dout0,
    output logic [7:0]            dout1
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [RAM_DEPTH];

    // Port 0 is written last so it takes the lane on a same-address collision.
    always_ff @(posedge clk) begin
        if (we1) mem[addr1] <= din1;
        if (we0) mem[addr0] <= din0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            if (re0) dout0 <= mem[addr0];
            if (re1) dout1 <= mem[addr1];
        end
    end
endmodule

module dp_sram_bytemask #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic                   web1,
    input  logic [WMASK_WIDTH-1:0] wmask1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0]  din1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   collision
);
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef DPRAM_CLEAR_ON_RESET_EN
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] counter, counter_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        clr_we      = 1'b0;
        case (state)
            CLEAR: begin
                clr_we      = 1'b1;
                counter_nxt = counter + 1'b1;
                if (&counter) state_nxt = IDLE;
            end
            default: ;
        endcase
    end

    assign clr_addr = counter;
    assign ready    = (state == IDLE);
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign ready    = 1'b1;
`endif

    logic acc0, acc1, wr0, wr1, col_nxt;

    assign acc0 = ready & ~csb0;
    assign acc1 = ready & ~csb1;
    assign wr0  = acc0 & ~web0;
    assign wr1  = acc1 & ~web1;
    // Same-address reads are harmless; only a write with a live mask flags.
    assign col_nxt = acc0 & acc1 & (addr0 == addr1) & ((wr0 & |wmask0) | (wr1 & |wmask1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) collision <= 1'b0;
        else     collision <= col_nxt;
    end

    // The clear sweep borrows port 0 while ready is low.
    logic [WMASK_WIDTH-1:0]      we0_l, we1_l;
    logic [ADDR_WIDTH-1:0]       addr0_l;
    logic [WMASK_WIDTH-1:0][7:0] din0_l, din1_l, dout0_l, dout1_l;

    assign we0_l   = clr_we ? '1 : ({WMASK_WIDTH{wr0}} & wmask0);
    assign we1_l   = {WMASK_WIDTH{wr1}} & wmask1;
    assign addr0_l = clr_we ? clr_addr : addr0;
    assign din0_l  = clr_we ? '0 : din0;
    assign din1_l  = din1;
    assign dout0   = dout0_l;
    assign dout1   = dout1_l;

    for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
        dp_sram_bytemask_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we0   (we0_l[i]),
            .we1   (we1_l[i]),
            .re0   (acc0 & web0),
            .re1   (acc1 & web1),
            .addr0 (addr0_l),
            .addr1 (addr1),
            .din0  (din0_l[i]),
            .din1  (din1_l[i]),
            .dout0 (dout0_l[i]),
            .dout1 (dout1_l[i])
        );
    end
endmodule

// File: tb/tb_dp_sram_bytemask.sv
// Scoreboard bench for dp_sram_bytemask (32-bit words, 16 deep); follows DPRAM_CLEAR_ON_RESET_EN.

module tb_dp_sram_bytemask;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready, collision;
    logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1, web1 = 1'b1;
    logic [3:0]  wmask0 = '0, wmask1 = '0, addr0 = '0, addr1 = '0;
    logic [31:0] din0 = '0, din1 = '0, dout0, dout1;

    always #5 clk = ~clk;

    dp_sram_bytemask #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1), .dout1(dout1),
        .collision(collision)
    );

`ifdef DPRAM_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    int          n_tests = 0, n_fail = 0;
    logic [31:0] model [16];
    logic [31:0] q0[$], q1[$];
    logic [31:0] last0 = '0, last1 = '0;
    logic        tb_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus from a negedge; checks outputs at the following negedge.
    task automatic cyc(input logic c0, input logic w0, input logic [3:0] m0, input logic [3:0] a0,
                       input logic [31:0] d0, input logic c1, input logic w1, input logic [3:0] m1,
                       input logic [3:0] a1, input logic [31:0] d1);
        logic acc0, acc1, wr0, wr1, ecol;
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
        csb1 = c1; web1 = w1; wmask1 = m1; addr1 = a1; din1 = d1;
        acc0 = tb_ready && !c0;
        acc1 = tb_ready && !c1;
        wr0  = acc0 && !w0;
        wr1  = acc1 && !w1;
        if (acc0 && w0) q0.push_back(model[a0]);
        if (acc1 && w1) q1.push_back(model[a1]);
        ecol = acc0 && acc1 && (a0 == a1) && ((wr0 && m0 != 0) || (wr1 && m1 != 0));
        for (int b = 0; b < 4; b++) if (wr1 && m1[b]) model[a1][8*b +: 8] = d1[8*b +: 8];
        for (int b = 0; b < 4; b++) if (wr0 && m0[b]) model[a0][8*b +: 8] = d0[8*b +: 8];
        @(posedge clk);
        @(negedge clk);
        csb0 = 1'b1; csb1 = 1'b1;
        if (q0.size() > 0) last0 = q0.pop_front();
        if (q1.size() > 0) last1 = q1.pop_front();
        chk("dout0", dout0, last0);
        chk("dout1", dout1, last1);
        chk("collision", {31'd0, collision}, {31'd0, ecol});
    endtask

    task automatic wr_0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        cyc(0, 0, m, a, d, 1, 1, 0, 0, 0);
    endtask
    task automatic rd_0(input logic [3:0] a);
        cyc(0, 1, 0, a, 0, 1, 1, 0, 0, 0);
    endtask
    task automatic rd_1(input logic [3:0] a);
        cyc(1, 1, 0, 0, 0, 0, 1, 0, a, 0);
    endtask
    task automatic idle();
        cyc(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    // Counts cycles from reset release until ready; optionally pokes writes at already-cleared words.
    task automatic wait_ready(input bit poke);
        int n = 0;
        tb_ready = 1'b0;
        while (ready !== 1'b1 && n < 40) begin
            if (poke) cyc(0, 0, 4'hF, (n == 0) ? 4'd0 : 4'(n - 1), 32'hDEADBEEF, 0, 1, 0, 4'd5, 0);
            else      idle();
            n++;
        end
        tb_ready = 1'b1;
        chk("ready_lat", 32'(n), 32'd16);
    endtask

    initial begin
        tb_ready = !CLR;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout0", dout0, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_col", {31'd0, collision}, 0);
        chk("rst_ready", {31'd0, ready}, {31'd0, !CLR});
        rst = 1'b0;
        if (CLR) begin
            wait_ready(0);
            for (int i = 0; i < 16; i++) rd_0(4'(i));
        end

        for (int i = 0; i < 8; i++)
            cyc(0, 0, 4'hF, 4'(2*i), $urandom, 0, 0, 4'hF, 4'(2*i+1), $urandom);

        wr_0(3, 32'hAABBCCDD, 4'b1111);
        wr_0(3, 32'h11223344, 4'b0101);
        rd_1(3);
        chk("masked_wr", dout1, 32'hAA22CC44);
        cyc(0, 0, 4'h0, 3, 32'hFFFFFFFF, 0, 1, 0, 3, 0);
        rd_0(3);
        chk("mask0_noop", dout0, 32'hAA22CC44);

        wr_0(5, 0, 4'hF);
        cyc(0, 0, 4'hF, 5, 32'h12345678, 0, 1, 0, 5, 0);
        chk("rd_first", dout1, 32'h0);
        idle();
        rd_0(5);
        chk("rd_after", dout0, 32'h12345678);

        wr_0(7, 0, 4'hF);
        cyc(0, 0, 4'b0011, 7, 32'h11111111, 0, 0, 4'b0110, 7, 32'h22222222);
        idle();
        rd_1(7);
        chk("ww_merge", dout1, 32'h00221111);

        wr_0(2, 32'hCAFEF00D, 4'hF);
        cyc(0, 1, 0, 2, 0, 0, 1, 0, 2, 0);
        chk("rr_same0", dout0, 32'hCAFEF00D);
        chk("rr_same1", dout1, 32'hCAFEF00D);

        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);

        cyc(0, 1, 0, 3, 0, 0, 1, 0, 7, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout0", dout0, 0);
        chk("arst_dout1", dout1, 0);
        chk("arst_col", {31'd0, collision}, 0);
        last0 = '0; last1 = '0;
        @(negedge clk);
        rst = 1'b0;
        if (CLR) begin
            tb_ready = 1'b0;
            for (int i = 0; i < 9; i++) cyc(0, 0, 4'hF, 4'(i), 32'hBADC0DE0, 1, 1, 0, 0, 0);
            rst = 1'b1;
            #1 chk("rst9_ready", {31'd0, ready}, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 16; i++) model[i] = '0;
            wait_ready(1);
        end
        for (int i = 0; i < 16; i++) rd_1(4'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
